// File: rtl/redmule_z_buffer_mb.sv
// Multi-bank Z/Y staging buffer between the streamer and the RedMulE array.
// NBANKS independent D x W tiles; bias load, bias push/result fill and Z drain
// each walk their own round-robin pointer so they can work on different tiles.
module redmule_z_buffer_mb #(
  parameter int unsigned DW     = 288,
  parameter int unsigned BITW   = 16,
  parameter int unsigned W      = 12,
  parameter int unsigned NBANKS = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          bias_en_i,
  input  logic [$clog2(W):0]            y_width_i,
  input  logic [$clog2(DW/BITW):0]      y_height_i,
  input  logic [$clog2(DW/BITW):0]      z_height_i,
  input  logic [$clog2(W):0]            z_width_i,
  input  logic                          y_valid_i,
  input  logic [DW-1:0]                 y_col_i,
  output logic                          y_ready_o,
  input  logic                          y_push_i,
  output logic [W*BITW-1:0]             y_data_o,
  output logic                          y_pushed_o,
  input  logic                          fill_i,
  input  logic [W*BITW-1:0]             fill_data_i,
  output logic                          z_valid_o,
  input  logic                          z_ready_i,
  output logic [DW-1:0]                 z_data_o,
  output logic [DW/8-1:0]               z_strb_o,
  output logic                          tile_done_o,
  output logic                          loaded_o,
  output logic                          overrun_o
);

  localparam int unsigned D  = DW / BITW;
  localparam int unsigned WW = $clog2(W) + 1;
  localparam int unsigned HW = $clog2(D) + 1;
  localparam int unsigned CW = $clog2(W);
  localparam int unsigned RW = $clog2(D);
  localparam int unsigned PW = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int unsigned BB = BITW / 8;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LOADED = 2'd1,
    ST_FULL   = 2'd2
  } tile_st_e;

  logic [BITW-1:0] mem_q [NBANKS][D][W];

  tile_st_e        state_q   [NBANKS];
  tile_st_e        state_d   [NBANKS];
  logic [WW-1:0]   snap_yw_q [NBANKS];
  logic [WW-1:0]   snap_yw_d [NBANKS];
  logic [HW-1:0]   snap_yh_q [NBANKS];
  logic [HW-1:0]   snap_yh_d [NBANKS];
  logic [HW-1:0]   snap_zh_q [NBANKS];
  logic [HW-1:0]   snap_zh_d [NBANKS];
  logic [WW-1:0]   snap_zw_q [NBANKS];
  logic [WW-1:0]   snap_zw_d [NBANKS];

  logic [PW-1:0]   lp_q, lp_d, fp_q, fp_d, sp_q, sp_d;
  logic [CW-1:0]   wi_q, wi_d, si_q, si_d;
  logic [RW-1:0]   di_q, di_d, fi_q, fi_d;
  logic            overrun_q, overrun_d;
  logic            tile_done_q, tile_done_d;
  logic            y_pushed_q, y_pushed_d;
  logic            alive_q;

  tile_st_e        st_lp, st_fp, st_sp;
  logic            lp_fresh, fp_fresh;
  logic [WW-1:0]   eff_yw;
  logic [HW-1:0]   eff_yh, eff_zh;
  logic            load_ok, push_ok;
  logic            load_hs, push_hs, fill_hs, store_hs;
  logic            load_last, push_last, fill_last, store_last;

  function automatic logic [WW-1:0] sat_w(input logic [WW-1:0] v);
    return (v == '0 || v > WW'(W)) ? WW'(W) : v;
  endfunction

  function automatic logic [HW-1:0] sat_h(input logic [HW-1:0] v);
    return (v == '0 || v > HW'(D)) ? HW'(D) : v;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NBANKS - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake qualification; a tile not yet snapshotted uses the live dimensions
  always_comb begin
    st_lp     = state_q[lp_q];
    st_fp     = state_q[fp_q];
    st_sp     = state_q[sp_q];
    lp_fresh  = (wi_q == '0);
    fp_fresh  = (st_fp == ST_EMPTY) && (fi_q == '0);
    eff_yw    = lp_fresh ? sat_w(y_width_i)  : snap_yw_q[lp_q];
    eff_yh    = fp_fresh ? sat_h(y_height_i) : snap_yh_q[fp_q];
    eff_zh    = fp_fresh ? sat_h(z_height_i) : snap_zh_q[fp_q];
    load_ok   = alive_q && bias_en_i && (st_lp == ST_EMPTY) &&
                !((lp_q == fp_q) && (di_q != '0));
    push_ok   = (st_fp == ST_LOADED) || (!bias_en_i && (st_fp == ST_EMPTY));
    load_hs   = y_valid_i && load_ok && !clear_i;
    push_hs   = y_push_i && push_ok && !clear_i;
    fill_hs   = fill_i && push_ok && !clear_i;
    store_hs  = (st_sp == ST_FULL) && z_ready_i && !clear_i;
    load_last  = (WW'(wi_q) == eff_yw - WW'(1));
    push_last  = (HW'(di_q) == eff_yh - HW'(1));
    fill_last  = (HW'(fi_q) == eff_zh - HW'(1));
    store_last = (WW'(si_q) == snap_zw_q[sp_q] - WW'(1));
  end

  // Next-state for tile states, snapshots, pointers and counters; clear wins
  always_comb begin
    state_d     = state_q;
    snap_yw_d   = snap_yw_q;
    snap_yh_d   = snap_yh_q;
    snap_zh_d   = snap_zh_q;
    snap_zw_d   = snap_zw_q;
    lp_d        = lp_q;
    fp_d        = fp_q;
    sp_d        = sp_q;
    wi_d        = wi_q;
    di_d        = di_q;
    fi_d        = fi_q;
    si_d        = si_q;
    overrun_d   = overrun_q | ((y_push_i | fill_i) & ~push_ok);
    tile_done_d = store_hs & store_last;
    y_pushed_d  = push_hs & push_last;

    if (load_hs) begin
      if (lp_fresh) begin
        snap_yw_d[lp_q] = sat_w(y_width_i);
        snap_yh_d[lp_q] = sat_h(y_height_i);
        snap_zh_d[lp_q] = sat_h(z_height_i);
        snap_zw_d[lp_q] = sat_w(z_width_i);
      end
      if (load_last) begin
        wi_d           = '0;
        state_d[lp_q]  = ST_LOADED;
        lp_d           = ptr_inc(lp_q);
      end else begin
        wi_d = wi_q + CW'(1);
      end
    end

    if (push_hs) di_d = push_last ? '0 : di_q + RW'(1);

    if (fill_hs) begin
      if (fp_fresh) begin
        snap_yw_d[fp_q] = sat_w(y_width_i);
        snap_yh_d[fp_q] = sat_h(y_height_i);
        snap_zh_d[fp_q] = sat_h(z_height_i);
        snap_zw_d[fp_q] = sat_w(z_width_i);
      end
      if (fill_last) begin
        // the push side follows fp, so an unfinished push count is dropped here
        fi_d          = '0;
        di_d          = '0;
        state_d[fp_q] = ST_FULL;
        fp_d          = ptr_inc(fp_q);
      end else begin
        fi_d = fi_q + RW'(1);
      end
    end

    if (store_hs) begin
      if (store_last) begin
        si_d          = '0;
        state_d[sp_q] = ST_EMPTY;
        sp_d          = ptr_inc(sp_q);
      end else begin
        si_d = si_q + CW'(1);
      end
    end

    if (clear_i) begin
      for (int unsigned b = 0; b < NBANKS; b++) state_d[b] = ST_EMPTY;
      lp_d        = '0;
      fp_d        = '0;
      sp_d        = '0;
      wi_d        = '0;
      di_d        = '0;
      fi_d        = '0;
      si_d        = '0;
      overrun_d   = 1'b0;
      tile_done_d = 1'b0;
      y_pushed_d  = 1'b0;
    end
  end

  // Control registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned b = 0; b < NBANKS; b++) begin
        state_q[b]   <= ST_EMPTY;
        snap_yw_q[b] <= '0;
        snap_yh_q[b] <= '0;
        snap_zh_q[b] <= '0;
        snap_zw_q[b] <= '0;
      end
      lp_q        <= '0;
      fp_q        <= '0;
      sp_q        <= '0;
      wi_q        <= '0;
      di_q        <= '0;
      fi_q        <= '0;
      si_q        <= '0;
      overrun_q   <= 1'b0;
      tile_done_q <= 1'b0;
      y_pushed_q  <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_yw_q   <= snap_yw_d;
      snap_yh_q   <= snap_yh_d;
      snap_zh_q   <= snap_zh_d;
      snap_zw_q   <= snap_zw_d;
      lp_q        <= lp_d;
      fp_q        <= fp_d;
      sp_q        <= sp_d;
      wi_q        <= wi_d;
      di_q        <= di_d;
      fi_q        <= fi_d;
      si_q        <= si_d;
      overrun_q   <= overrun_d;
      tile_done_q <= tile_done_d;
      y_pushed_q  <= y_pushed_d;
      alive_q     <= 1'b1;
    end
  end

  // Tile storage: bias columns and result rows, never reset
  always_ff @(posedge clk_i) begin
    if (load_hs)
      for (int unsigned r = 0; r < D; r++)
        mem_q[lp_q][RW'(r)][wi_q] <= y_col_i[r*BITW +: BITW];
    if (fill_hs)
      for (int unsigned c = 0; c < W; c++)
        mem_q[fp_q][fi_q][CW'(c)] <= fill_data_i[c*BITW +: BITW];
  end

  // Bias row read, only driven for a legal push while bias is enabled
  always_comb begin
    y_data_o = '0;
    if (y_push_i && push_ok && bias_en_i)
      for (int unsigned c = 0; c < W; c++)
        y_data_o[c*BITW +: BITW] = mem_q[fp_q][di_q][CW'(c)];
  end

  // Result column read and byte strobes for the draining tile
  always_comb begin
    z_data_o = '0;
    z_strb_o = '0;
    if (st_sp == ST_FULL)
      for (int unsigned r = 0; r < D; r++) begin
        z_data_o[r*BITW +: BITW] = mem_q[sp_q][RW'(r)][si_q];
        if (HW'(r) < snap_zh_q[sp_q]) z_strb_o[r*BB +: BB] = '1;
      end
  end

  assign y_ready_o   = load_ok;
  assign z_valid_o   = (st_sp == ST_FULL);
  assign loaded_o    = (st_fp == ST_LOADED);
  assign overrun_o   = overrun_q;
  assign tile_done_o = tile_done_q;
  assign y_pushed_o  = y_pushed_q;

endmodule

// File: tb/tb_redmule_z_buffer_mb.sv
// Scoreboard bench for redmule_z_buffer_mb: expected Z beats are queued as
// tiles complete filling and popped as the buffer drains them.
module tb_redmule_z_buffer_mb;

  localparam int unsigned DW = 288, BITW = 16, W = 12, NBANKS = 2;
  localparam int unsigned D = DW / BITW, SW = DW / 8, RWD = W * BITW;

  logic                 clk_i = 1'b0;
  logic                 rst_i, clear_i, bias_en_i;
  logic [$clog2(W):0]   y_width_i, z_width_i;
  logic [$clog2(D):0]   y_height_i, z_height_i;
  logic                 y_valid_i, y_ready_o, y_push_i, y_pushed_o;
  logic [DW-1:0]        y_col_i, z_data_o;
  logic [RWD-1:0]       y_data_o, fill_data_i;
  logic                 fill_i, z_valid_o, z_ready_i, tile_done_o, loaded_o, overrun_o;
  logic [SW-1:0]        z_strb_o;

  redmule_z_buffer_mb #(.DW(DW), .BITW(BITW), .W(W), .NBANKS(NBANKS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .bias_en_i(bias_en_i),
    .y_width_i(y_width_i), .y_height_i(y_height_i), .z_height_i(z_height_i),
    .z_width_i(z_width_i), .y_valid_i(y_valid_i), .y_col_i(y_col_i),
    .y_ready_o(y_ready_o), .y_push_i(y_push_i), .y_data_o(y_data_o),
    .y_pushed_o(y_pushed_o), .fill_i(fill_i), .fill_data_i(fill_data_i),
    .z_valid_o(z_valid_o), .z_ready_i(z_ready_i), .z_data_o(z_data_o),
    .z_strb_o(z_strb_o), .tile_done_o(tile_done_o), .loaded_o(loaded_o),
    .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] dmask;
    logic [SW-1:0] strb;
  } beat_t;

  beat_t          sb[$];
  logic [RWD-1:0] cur_rows [D];
  int             cur_cnt = 0;
  int             errors = 0, checks = 0;

  function automatic logic [DW-1:0] rand_col();
    logic [DW-1:0] v;
    for (int i = 0; i < DW; i += 16) v[i +: 16] = 16'($urandom);
    return v;
  endfunction

  function automatic logic [RWD-1:0] rand_row();
    logic [RWD-1:0] v;
    for (int i = 0; i < RWD; i += 16) v[i +: 16] = 16'($urandom);
    return v;
  endfunction

  function automatic logic [SW-1:0] strb_for(input int h);
    logic [SW-1:0] s;
    s = '0;
    for (int k = 0; k < h; k++) s[k*2 +: 2] = 2'b11;
    return s;
  endfunction

  function automatic logic [DW-1:0] dmask_for(input int h);
    logic [DW-1:0] m;
    m = '0;
    for (int k = 0; k < h; k++) m[k*BITW +: BITW] = '1;
    return m;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    sb.delete();
    cur_cnt = 0;
  endtask

  task automatic fill_rows(input int n);
    for (int i = 0; i < n; i++) begin
      fill_i = 1'b1;
      fill_data_i = rand_row();
      cur_rows[cur_cnt] = fill_data_i;
      cur_cnt++;
      step();
    end
    fill_i = 1'b0;
  endtask

  // Expected beats for a completed tile: column c holds word c of every row
  task automatic finish_tile(input int zh, input int zw);
    beat_t e;
    for (int c = 0; c < zw; c++) begin
      e.data = '0;
      for (int r = 0; r < zh; r++) e.data[r*BITW +: BITW] = cur_rows[r][c*BITW +: BITW];
      e.dmask = dmask_for(zh);
      e.strb  = strb_for(zh);
      sb.push_back(e);
    end
    cur_cnt = 0;
  endtask

  task automatic drain(input int n, input bit toggle, output int ndone, output int cyc);
    int acc;
    bit hold_v, rdy;
    logic [DW-1:0] held;
    beat_t e;
    acc = 0; ndone = 0; cyc = 0; hold_v = 0; held = '0;
    while (acc < n && cyc < 400) begin
      rdy = toggle ? (cyc % 2 == 1) : 1'b1;
      z_ready_i = rdy;
      #1;
      if (hold_v) begin
        checks++;
        if (z_data_o !== held) begin
          errors++; $display("FAIL z_stable: got %h required %h", z_data_o, held);
        end
      end
      if (z_valid_o && rdy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL z_extra_beat: got beat with empty scoreboard");
        end else begin
          e = sb.pop_front();
          if ((z_data_o & e.dmask) !== e.data) begin
            errors++; $display("FAIL z_data: got %h required %h", z_data_o & e.dmask, e.data);
          end
          checks++;
          if (z_strb_o !== e.strb) begin
            errors++; $display("FAIL z_strb: got %h required %h", z_strb_o, e.strb);
          end
        end
        acc++; hold_v = 0;
      end else if (z_valid_o) begin
        held = z_data_o; hold_v = 1;
      end
      step();
      if (tile_done_o) ndone++;
      cyc++;
    end
    z_ready_i = 1'b0;
    checks++;
    if (acc != n) begin
      errors++; $display("FAIL drain_count: got %0d beats required %0d", acc, n);
    end
    step();
    if (tile_done_o) ndone++;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({y_ready_o, z_valid_o, loaded_o, overrun_o, tile_done_o, y_pushed_o} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 000000",
        {y_ready_o, z_valid_o, loaded_o, overrun_o, tile_done_o, y_pushed_o});
    end
    checks++;
    if (z_data_o !== '0 || z_strb_o !== '0 || y_data_o !== '0) begin
      errors++; $display("FAIL reset_data: got z=%h s=%h y=%h required 0", z_data_o, z_strb_o, y_data_o);
    end
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    checks++;
    if (y_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_early: got %b required 0", y_ready_o); end
    step();
    checks++;
    if (y_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", y_ready_o); end
  endtask

  task automatic test_bias_path();
    logic [DW-1:0]  bcol [W];
    logic [RWD-1:0] exp_row;
    int nd, cyc;
    bias_en_i = 1'b1; y_width_i = 12; y_height_i = 18; z_height_i = 18; z_width_i = 12;
    for (int c = 0; c < W; c++) begin
      y_valid_i = 1'b1;
      y_col_i = rand_col();
      bcol[c] = y_col_i;
      #1;
      if (c == 0) begin
        checks++;
        if (y_ready_o !== 1'b1) begin errors++; $display("FAIL bias_ready: got %b required 1", y_ready_o); end
      end
      if (c == W - 1) begin
        checks++;
        if (loaded_o !== 1'b0) begin errors++; $display("FAIL bias_loaded_early: got %b required 0", loaded_o); end
      end
      step();
    end
    y_valid_i = 1'b0;
    #1;
    checks++;
    if (loaded_o !== 1'b1) begin errors++; $display("FAIL bias_loaded: got %b required 1", loaded_o); end
    checks++;
    if (y_data_o !== '0) begin errors++; $display("FAIL bias_idle_data: got %h required 0", y_data_o); end
    step();
    for (int r = 0; r < D; r++) begin
      y_push_i = 1'b1;
      fill_i = 1'b1;
      fill_data_i = rand_row();
      cur_rows[cur_cnt] = fill_data_i;
      cur_cnt++;
      for (int c = 0; c < W; c++) exp_row[c*BITW +: BITW] = bcol[c][r*BITW +: BITW];
      #1;
      checks++;
      if (y_data_o !== exp_row) begin
        errors++; $display("FAIL bias_row%0d: got %h required %h", r, y_data_o, exp_row);
      end
      step();
      if (r == D - 2) begin
        checks++;
        if (y_pushed_o !== 1'b0) begin errors++; $display("FAIL pushed_early: got %b required 0", y_pushed_o); end
      end
      if (r == D - 1) begin
        checks++;
        if (y_pushed_o !== 1'b1) begin errors++; $display("FAIL pushed: got %b required 1", y_pushed_o); end
        checks++;
        if (loaded_o !== 1'b0) begin errors++; $display("FAIL fp_advance: got loaded %b required 0", loaded_o); end
      end
    end
    y_push_i = 1'b0;
    fill_i = 1'b0;
    finish_tile(18, 12);
    drain(12, 1'b0, nd, cyc);
    checks++;
    if (nd != 1) begin errors++; $display("FAIL bias_tile_done: got %0d pulses required 1", nd); end
  endtask

  task automatic test_overlap();
    int nd, cyc;
    do_clear();
    bias_en_i = 1'b0; z_ready_i = 1'b0; z_height_i = 4; z_width_i = 3;
    #1;
    checks++;
    if (y_ready_o !== 1'b0) begin errors++; $display("FAIL nobias_ready: got %b required 0", y_ready_o); end
    step();
    fill_rows(4); finish_tile(4, 3);
    fill_rows(4); finish_tile(4, 3);
    checks++;
    if (z_valid_o !== 1'b1 || overrun_o !== 1'b0) begin
      errors++; $display("FAIL ovl_full: got valid %b overrun %b required 1 0", z_valid_o, overrun_o);
    end
    fill_i = 1'b1; fill_data_i = rand_row();
    step();
    fill_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovl_overrun: got %b required 1", overrun_o); end
    drain(6, 1'b0, nd, cyc);
    checks++;
    if (nd != 2) begin errors++; $display("FAIL ovl_done: got %0d pulses required 2", nd); end
    checks++;
    if (cyc != 6) begin errors++; $display("FAIL ovl_b2b: got %0d cycles required 6", cyc); end
    checks++;
    if (z_valid_o !== 1'b0 || overrun_o !== 1'b1) begin
      errors++; $display("FAIL ovl_after: got valid %b overrun %b required 0 1", z_valid_o, overrun_o);
    end
    fill_rows(4); finish_tile(4, 3);
    checks++;
    if (z_valid_o !== 1'b1) begin errors++; $display("FAIL ovl_sp_wrap: got %b required 1", z_valid_o); end
    drain(3, 1'b0, nd, cyc);
  endtask

  task automatic test_snapshot();
    int nd, cyc;
    do_clear();
    bias_en_i = 1'b0; z_height_i = 4; z_width_i = 2;
    fill_rows(1);
    z_height_i = 2;
    fill_rows(1);
    checks++;
    if (z_valid_o !== 1'b0) begin errors++; $display("FAIL snap_early: got %b required 0", z_valid_o); end
    fill_rows(2); finish_tile(4, 2);
    checks++;
    if (z_valid_o !== 1'b1) begin errors++; $display("FAIL snap_full: got %b required 1", z_valid_o); end
    checks++;
    if (z_strb_o !== 36'h0_0000_00FF) begin errors++; $display("FAIL snap_strb: got %h required 00000000ff", z_strb_o); end
    drain(2, 1'b0, nd, cyc);
    checks++;
    if (nd != 1) begin errors++; $display("FAIL snap_done: got %0d required 1", nd); end
  endtask

  task automatic test_saturation();
    do_clear();
    bias_en_i = 1'b0; z_height_i = 0; z_width_i = 0;
    fill_rows(17);
    checks++;
    if (z_valid_o !== 1'b0) begin errors++; $display("FAIL sat_early: got %b required 0", z_valid_o); end
    fill_rows(1); finish_tile(18, 12);
    checks++;
    if (z_valid_o !== 1'b1) begin errors++; $display("FAIL sat_full: got %b required 1", z_valid_o); end
    checks++;
    if (z_strb_o !== {SW{1'b1}}) begin errors++; $display("FAIL sat_strb: got %h required all ones", z_strb_o); end
  endtask

  task automatic test_backpressure();
    int nd, cyc;
    drain(12, 1'b1, nd, cyc);
    checks++;
    if (cyc != 24) begin errors++; $display("FAIL bp_cycles: got %0d required 24", cyc); end
    checks++;
    if (nd != 1 || z_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_done: got %0d pulses valid %b required 1 0", nd, z_valid_o);
    end
  endtask

  task automatic test_clear_recovery();
    beat_t e;
    int nd, cyc;
    do_clear();
    bias_en_i = 1'b0; z_height_i = 2; z_width_i = 4;
    fill_rows(2); finish_tile(2, 4);
    fill_rows(2); finish_tile(2, 4);
    fill_i = 1'b1; fill_data_i = rand_row();
    step();
    fill_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b1) begin errors++; $display("FAIL clr_overrun_set: got %b required 1", overrun_o); end
    z_ready_i = 1'b1;
    #1;
    e = sb.pop_front();
    checks++;
    if ((z_data_o & e.dmask) !== e.data) begin
      errors++; $display("FAIL clr_first_beat: got %h required %h", z_data_o & e.dmask, e.data);
    end
    step();
    clear_i = 1'b1; fill_i = 1'b1; fill_data_i = rand_row();
    step();
    clear_i = 1'b0; fill_i = 1'b0; z_ready_i = 1'b0;
    sb.delete(); cur_cnt = 0;
    checks++;
    if ({z_valid_o, overrun_o, tile_done_o, loaded_o} !== 4'b0) begin
      errors++; $display("FAIL clr_state: got %b required 0000", {z_valid_o, overrun_o, tile_done_o, loaded_o});
    end
    step();
    checks++;
    if (tile_done_o !== 1'b0) begin errors++; $display("FAIL clr_done: got %b required 0", tile_done_o); end
    fill_rows(1);
    checks++;
    if (z_valid_o !== 1'b0) begin errors++; $display("FAIL clr_fill_cnt: got %b required 0", z_valid_o); end
    fill_rows(1); finish_tile(2, 4);
    drain(4, 1'b0, nd, cyc);
    checks++;
    if (nd != 1) begin errors++; $display("FAIL clr_redrain: got %0d required 1", nd); end
  endtask

  task automatic test_async_reset();
    do_clear();
    bias_en_i = 1'b1; y_width_i = 12;
    for (int c = 0; c < 3; c++) begin
      y_valid_i = 1'b1; y_col_i = rand_col();
      step();
    end
    y_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (y_ready_o !== 1'b0) begin errors++; $display("FAIL arst_ready: got %b required 0", y_ready_o); end
    step();
    rst_i = 1'b0;
    #1;
    checks++;
    if (y_ready_o !== 1'b0) begin errors++; $display("FAIL arst_release: got %b required 0", y_ready_o); end
    step();
    checks++;
    if (y_ready_o !== 1'b1) begin errors++; $display("FAIL arst_recover: got %b required 1", y_ready_o); end
    for (int c = 0; c < W; c++) begin
      y_valid_i = 1'b1; y_col_i = rand_col();
      step();
      if (c == W - 2) begin
        checks++;
        if (loaded_o !== 1'b0) begin errors++; $display("FAIL arst_wi: got loaded %b required 0", loaded_o); end
      end
    end
    y_valid_i = 1'b0;
    checks++;
    if (loaded_o !== 1'b1) begin errors++; $display("FAIL arst_loaded: got %b required 1", loaded_o); end
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; bias_en_i = 1'b1;
    y_width_i = 12; y_height_i = 18; z_height_i = 18; z_width_i = 12;
    y_valid_i = 1'b0; y_col_i = '0; y_push_i = 1'b0;
    fill_i = 1'b0; fill_data_i = '0; z_ready_i = 1'b0;
    test_reset();
    test_bias_path();
    test_overlap();
    test_snapshot();
    test_saturation();
    test_backpressure();
    test_clear_recovery();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
